// File: rtl/readback_c2h_sender_pkg.sv
// Shared widths, FSM state encodings and helpers for the readback C2H sender.
// Everything that used to live in parameters.vh is collected here.
package readback_c2h_sender_pkg;

    localparam int XDMA_AXI_DATA_WIDTH = 256;
    localparam int RB_IN_WIDTH         = 2 * XDMA_AXI_DATA_WIDTH;

    localparam logic [1:0] ST_IDLE       = 2'd0;
    localparam logic [1:0] ST_SEND_LO    = 2'd1;
    localparam logic [1:0] ST_SEND_HI    = 2'd2;
    localparam logic [1:0] ST_FLUSH_WAIT = 2'd3;

    // Width of a counter that must hold 0 .. n-1; never narrower than one bit.
    function automatic int cnt_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/readback_c2h_sender_sync_fifo.sv
// Single-clock FIFO with registered read data and full/empty flags.
// DEPTH must be a power of two so the pointers wrap on their own.
module sync_fifo
    import readback_c2h_sender_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    output logic             full,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             empty
);

    localparam int            AW       = cnt_width(DEPTH);
    localparam logic [AW:0]   FULL_CNT = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             do_wr;
    logic             do_rd;

    assign full  = (count == FULL_CNT);
    assign empty = (count == '0);

    // A write is refused when full even if a read happens in the same cycle.
    assign do_wr = wr_en & ~full;
    assign do_rd = rd_en & ~empty;

    // NOTE: the storage array has no reset; only pointers, count and the
    // read register are cleared, which is enough to make old contents unreachable.
    always_ff @(posedge clk) begin
        if (do_wr) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge value of every other flop.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            rd_data <= '0;
        end else begin
            if (do_wr) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_rd) begin
                rd_ptr  <= rd_ptr + AW'(1);
                rd_data <= mem[rd_ptr];
            end
            case ({do_wr, do_rd})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/readback_c2h_sender.sv
// Streams DRAM readback words to XDMA C2H channel 0 as two half-width beats,
// packetised every PKT_BEATS beats, with a flush request that closes a short packet.
module readback_c2h_sender
    import readback_c2h_sender_pkg::*;
#(
    parameter int IN_WIDTH   = RB_IN_WIDTH,
    parameter int OUT_WIDTH  = XDMA_AXI_DATA_WIDTH,
    parameter int FIFO_DEPTH = 16,
    parameter int PKT_BEATS  = 64
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [IN_WIDTH-1:0]    rd_data_in,
    input  logic                   rd_valid_in,
    output logic                   rd_ready_out,
    input  logic                   flush,
    output logic                   flush_done,
    output logic [OUT_WIDTH-1:0]   c2h_tdata_0,
    output logic                   c2h_tvalid_0,
    input  logic                   c2h_tready_0,
    output logic                   c2h_tlast_0,
    output logic [OUT_WIDTH/8-1:0] c2h_tkeep_0,
    output logic                   overflow,
    output logic [31:0]            words_sent
);

    localparam int            CW        = cnt_width(PKT_BEATS);
    localparam logic [CW-1:0] LAST_BEAT = CW'(PKT_BEATS - 1);

    logic [1:0]          state_q;
    logic [1:0]          state_d;
    logic [CW-1:0]       beat_cnt_q;
    logic                flush_pending_q;
    logic                hi_held_q;
    logic                force_held_q;
    logic                overflow_q;
    logic [31:0]         words_sent_q;

    logic [IN_WIDTH-1:0] fifo_rd_data;
    logic                fifo_full;
    logic                fifo_empty;
    logic                fifo_push;
    logic                fifo_pop;

    logic                beat_hs;
    logic                hi_hs;
    logic                force_now;
    logic                idle_flush;

    sync_fifo #(
        .WIDTH (IN_WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (fifo_push),
        .wr_data (rd_data_in),
        .full    (fifo_full),
        .rd_en   (fifo_pop),
        .rd_data (fifo_rd_data),
        .empty   (fifo_empty)
    );

    assign rd_ready_out = rst_n & ~fifo_full;
    assign fifo_push    = rd_valid_in & rd_ready_out;

    assign c2h_tvalid_0 = (state_q == ST_SEND_LO) || (state_q == ST_SEND_HI);
    assign c2h_tdata_0  = (state_q == ST_SEND_HI) ? fifo_rd_data[IN_WIDTH-1 -: OUT_WIDTH]
                                                  : fifo_rd_data[OUT_WIDTH-1:0];
    assign c2h_tkeep_0  = '1;

    assign beat_hs = c2h_tvalid_0 & c2h_tready_0;
    assign hi_hs   = (state_q == ST_SEND_HI) & c2h_tready_0;

    // Once a stalled high beat has been presented, its flush-tlast decision is frozen.
    assign force_now  = hi_held_q ? force_held_q : (flush_pending_q & fifo_empty);
    assign idle_flush = (state_q == ST_IDLE) & fifo_empty & (flush | flush_pending_q);

    assign c2h_tlast_0 = (state_q == ST_SEND_HI) & ((beat_cnt_q == LAST_BEAT) | force_now);
    assign flush_done  = (state_q == ST_FLUSH_WAIT);
    assign overflow    = overflow_q;
    assign words_sent  = words_sent_q;

    // The held word stays in the FIFO read register until the next pop.
    assign fifo_pop = ((state_q == ST_IDLE) & ~fifo_empty) |
                      (hi_hs & ~force_now & ~fifo_empty);

    // NOTE: state_d gets a default before the case so no path leaves it unassigned.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    state_d = ST_SEND_LO;
                end else if (flush || flush_pending_q) begin
                    state_d = ST_FLUSH_WAIT;
                end
            end
            ST_SEND_LO: begin
                if (c2h_tready_0) begin
                    state_d = ST_SEND_HI;
                end
            end
            ST_SEND_HI: begin
                if (c2h_tready_0) begin
                    if (force_now) begin
                        state_d = ST_FLUSH_WAIT;
                    end else if (!fifo_empty) begin
                        state_d = ST_SEND_LO;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            ST_FLUSH_WAIT: state_d = ST_IDLE;
            default:       state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q         <= ST_IDLE;
            beat_cnt_q      <= '0;
            flush_pending_q <= 1'b0;
            hi_held_q       <= 1'b0;
            force_held_q    <= 1'b0;
            overflow_q      <= 1'b0;
            words_sent_q    <= '0;
        end else begin
            state_q <= state_d;

            if (beat_hs) begin
                beat_cnt_q <= c2h_tlast_0 ? '0 : beat_cnt_q + CW'(1);
            end else if (idle_flush) begin
                beat_cnt_q <= '0;
            end

            // Repeated flush pulses collapse into the single pending request.
            if (state_d == ST_FLUSH_WAIT) begin
                flush_pending_q <= 1'b0;
            end else if (flush) begin
                flush_pending_q <= 1'b1;
            end

            if ((state_q == ST_SEND_HI) && !c2h_tready_0) begin
                hi_held_q    <= 1'b1;
                force_held_q <= force_now;
            end else begin
                hi_held_q    <= 1'b0;
                force_held_q <= 1'b0;
            end

            if (rd_valid_in && fifo_full) begin
                overflow_q <= 1'b1;
            end

            if (hi_hs) begin
                words_sent_q <= words_sent_q + 32'd1;
            end
        end
    end

endmodule

// File: tb/tb_readback_c2h_sender.sv
// Self-checking bench for readback_c2h_sender: scenario table driven against a
// beat scoreboard, plus hand-written latency, overflow and mid-packet reset sequences.
module tb_readback_c2h_sender;

    localparam int IW = 512;
    localparam int OW = 256;
    localparam int PB = 64;

    logic          clk;
    logic          rst_n;
    logic [IW-1:0] rd_data_in;
    logic          rd_valid_in;
    logic          rd_ready_out;
    logic          flush;
    logic          flush_done;
    logic [OW-1:0] c2h_tdata_0;
    logic          c2h_tvalid_0;
    logic          c2h_tready_0;
    logic          c2h_tlast_0;
    logic [OW/8-1:0] c2h_tkeep_0;
    logic          overflow;
    logic [31:0]   words_sent;

    readback_c2h_sender #(
        .IN_WIDTH   (IW),
        .OUT_WIDTH  (OW),
        .FIFO_DEPTH (16),
        .PKT_BEATS  (PB)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .rd_data_in   (rd_data_in),
        .rd_valid_in  (rd_valid_in),
        .rd_ready_out (rd_ready_out),
        .flush        (flush),
        .flush_done   (flush_done),
        .c2h_tdata_0  (c2h_tdata_0),
        .c2h_tvalid_0 (c2h_tvalid_0),
        .c2h_tready_0 (c2h_tready_0),
        .c2h_tlast_0  (c2h_tlast_0),
        .c2h_tkeep_0  (c2h_tkeep_0),
        .overflow     (overflow),
        .words_sent   (words_sent)
    );

    typedef struct {
        logic [OW-1:0] data;
        logic          last;
    } beat_t;

    typedef struct {
        string name;
        int    n_words;
        int    rdy_mode;   // 0 = never ready, 1 = always ready, 2 = toggle
        int    n_flush;
        int    exp_beats;
        int    exp_tlasts;
        int    exp_dones;
        int    exp_span;   // cycles from first to last beat, -1 = unchecked
    } vec_t;

    beat_t exp_q[$];
    vec_t  vecs[6];

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    int rdy_mode = 1;
    int mb = 0;
    int beats_seen, tlasts_seen, done_seen;
    int first_hs_cyc, last_hs_cyc, tlast_cyc, done_cyc, flush_cyc;
    logic          prev_stall;
    logic [OW-1:0] prev_data;
    logic          prev_last;

    task automatic check(input string name, input logic [IW-1:0] act, input logic [IW-1:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [IW-1:0] mk_word(input int w);
        logic [IW-1:0] r;
        for (int c = 0; c < IW / 32; c++) begin
            r[c*32 +: 32] = {8'(w), 8'(c), 16'(w * 59 + c)};
        end
        return r;
    endfunction

    task automatic model_beat(input logic [OW-1:0] d);
        beat_t b;
        b.data = d;
        b.last = (mb == PB - 1);
        exp_q.push_back(b);
        mb = b.last ? 0 : mb + 1;
    endtask

    task automatic expect_word(input int w);
        logic [IW-1:0] word;
        word = mk_word(w);
        model_beat(word[OW-1:0]);
        model_beat(word[IW-1:OW]);
    endtask

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    initial begin
        c2h_tready_0 = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            case (rdy_mode)
                0:       c2h_tready_0 = 1'b0;
                1:       c2h_tready_0 = 1'b1;
                default: c2h_tready_0 = ~c2h_tready_0;
            endcase
        end
    end

    // Output monitor: compares each accepted beat to the scoreboard and checks stall stability.
    initial begin
        beat_t b;
        prev_stall = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                prev_stall = 1'b0;
            end else begin
                if (prev_stall) begin
                    check("stall_hold", {c2h_tvalid_0, c2h_tlast_0, c2h_tdata_0},
                          {1'b1, prev_last, prev_data});
                end
                if (c2h_tvalid_0 && c2h_tready_0) begin
                    if (exp_q.size() == 0) begin
                        check("beat_expected", IW'(exp_q.size()), IW'(1));
                    end else begin
                        b = exp_q.pop_front();
                        check("beat", {c2h_tlast_0, c2h_tdata_0}, {b.last, b.data});
                    end
                    if (beats_seen == 0) first_hs_cyc = cyc;
                    last_hs_cyc = cyc;
                    beats_seen++;
                    if (c2h_tlast_0) begin
                        tlasts_seen++;
                        tlast_cyc = cyc;
                    end
                end
                prev_stall = c2h_tvalid_0 && !c2h_tready_0;
                prev_data  = c2h_tdata_0;
                prev_last  = c2h_tlast_0;
                if (flush_done) begin
                    done_seen++;
                    done_cyc = cyc;
                end
            end
        end
    end

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst_n       = 1'b0;
        rd_valid_in = 1'b0;
        flush       = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("rst_tvalid", IW'(c2h_tvalid_0), IW'(0));
        check("rst_tlast", IW'(c2h_tlast_0), IW'(0));
        check("rst_flush_done", IW'(flush_done), IW'(0));
        check("rst_rd_ready", IW'(rd_ready_out), IW'(0));
        check("rst_tdata", IW'(c2h_tdata_0), IW'(0));
        check("rst_words_sent", IW'(words_sent), IW'(0));
        exp_q.delete();
        mb = 0;
        beats_seen = 0; tlasts_seen = 0; done_seen = 0;
        first_hs_cyc = 0; last_hs_cyc = 0; tlast_cyc = 0; done_cyc = 0; flush_cyc = 0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic send_words(input int n);
        int i = 0;
        for (int k = 0; k < 4000 && i < n; k++) begin
            @(posedge clk);
            #1;
            if (rd_ready_out) begin
                rd_valid_in = 1'b1;
                rd_data_in  = mk_word(i);
                expect_word(i);
                i++;
            end else begin
                rd_valid_in = 1'b0;
            end
        end
        check("send_budget", IW'(i), IW'(n));
        @(posedge clk);
        #1;
        rd_valid_in = 1'b0;
    endtask

    task automatic pulse_flush(input int n);
        for (int f = 0; f < n; f++) begin
            if (f == 0) flush_cyc = cyc;
            flush = 1'b1;
            if (exp_q.size() > 0) exp_q[exp_q.size() - 1].last = 1'b1;
            mb = 0;
            @(posedge clk);
            #1;
            flush = 1'b0;
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        rst_n       = 1'b0;
        rd_valid_in = 1'b0;
        rd_data_in  = '0;
        flush       = 1'b0;

        vecs[0] = '{"three_words",    3, 1, 0,  6, 0, 0,  5};
        vecs[1] = '{"full_packet",   32, 1, 0, 64, 1, 0, 63};
        vecs[2] = '{"flush_stall",    5, 2, 1, 10, 1, 1, -1};
        vecs[3] = '{"flush_idle",     0, 1, 1,  0, 0, 1, -1};
        vecs[4] = '{"two_pkts_flush",40, 2, 1, 80, 2, 1, -1};
        vecs[5] = '{"double_flush",   6, 2, 2, 12, 1, 1, -1};

        for (int v = 0; v < 6; v++) begin
            do_reset();
            rdy_mode = vecs[v].rdy_mode;
            send_words(vecs[v].n_words);
            pulse_flush(vecs[v].n_flush);
            for (int k = 0; k < 3000 && !(exp_q.size() == 0 && done_seen >= vecs[v].exp_dones); k++)
                @(posedge clk);
            repeat (8) @(posedge clk);
            @(negedge clk);
            check({vecs[v].name, "_drain"}, IW'(exp_q.size()), IW'(0));
            check({vecs[v].name, "_beats"}, IW'(beats_seen), IW'(vecs[v].exp_beats));
            check({vecs[v].name, "_tlasts"}, IW'(tlasts_seen), IW'(vecs[v].exp_tlasts));
            check({vecs[v].name, "_dones"}, IW'(done_seen), IW'(vecs[v].exp_dones));
            check({vecs[v].name, "_words_sent"}, IW'(words_sent), IW'(vecs[v].n_words));
            check({vecs[v].name, "_overflow"}, IW'(overflow), IW'(0));
            if (vecs[v].exp_span >= 0)
                check({vecs[v].name, "_span"}, IW'(last_hs_cyc - first_hs_cyc), IW'(vecs[v].exp_span));
            if (vecs[v].n_flush > 0 && vecs[v].n_words > 0)
                check({vecs[v].name, "_done_after_tlast"}, IW'(done_cyc - tlast_cyc), IW'(1));
            if (vecs[v].n_flush > 0 && vecs[v].n_words == 0)
                check({vecs[v].name, "_done_after_flush"}, IW'(done_cyc - flush_cyc), IW'(1));
        end

        // Two-cycle latency from an accepted word to the first tvalid.
        do_reset();
        rdy_mode = 1;
        @(posedge clk);
        #1;
        rd_valid_in = 1'b1;
        rd_data_in  = mk_word(7);
        expect_word(7);
        @(posedge clk);
        #1;
        rd_valid_in = 1'b0;
        check("latency_c1_tvalid", IW'(c2h_tvalid_0), IW'(0));
        @(posedge clk);
        #1;
        check("latency_c2_tvalid", IW'(c2h_tvalid_0), IW'(1));
        repeat (6) @(posedge clk);
        @(negedge clk);
        check("latency_drain", IW'(exp_q.size()), IW'(0));

        // Fill with the sink stalled: 16 in the FIFO plus one held word, then overflow.
        do_reset();
        rdy_mode = 0;
        for (int i = 0; i < 17; i++) begin
            @(posedge clk);
            #1;
            check("fill_ready", IW'(rd_ready_out), IW'(1));
            rd_valid_in = 1'b1;
            rd_data_in  = mk_word(100 + i);
        end
        @(posedge clk);
        #1;
        check("full_ready_low", IW'(rd_ready_out), IW'(0));
        check("overflow_before", IW'(overflow), IW'(0));
        rd_data_in = mk_word(200);
        @(posedge clk);
        #1;
        rd_valid_in = 1'b0;
        check("overflow_set", IW'(overflow), IW'(1));
        check("held_tvalid", IW'(c2h_tvalid_0), IW'(1));
        check("held_tdata_lo", IW'(c2h_tdata_0), IW'(mk_word(100) & {{(IW-OW){1'b0}}, {OW{1'b1}}}));

        // Reset mid-packet discards the held word and the FIFO.
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        check("midrst_tvalid", IW'(c2h_tvalid_0), IW'(0));
        check("midrst_tlast", IW'(c2h_tlast_0), IW'(0));
        check("midrst_overflow", IW'(overflow), IW'(0));
        check("midrst_words_sent", IW'(words_sent), IW'(0));
        check("midrst_rd_ready", IW'(rd_ready_out), IW'(0));
        exp_q.delete();
        beats_seen = 0;
        rst_n    = 1'b1;
        rdy_mode = 1;
        repeat (30) @(posedge clk);
        @(negedge clk);
        check("midrst_no_beats", IW'(beats_seen), IW'(0));
        check("midrst_ready_back", IW'(rd_ready_out), IW'(1));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
